// File: rtl/ibex_pkg.sv
// ibex_pkg: ALU opcode enumeration and the helper functions used by the
// shared branch/MUL adder pipeline (ibex_branch_mul_alu_pipe).
// Optional feature macro: IBEX_BMA_MINMAX_EN (adds ALU_MIN/MINU/MAX/MAXU support).
package ibex_pkg;

   typedef enum logic [6:0] {
      ALU_ADD  = 7'd0,
      ALU_SUB  = 7'd1,
      ALU_XOR  = 7'd2,
      ALU_OR   = 7'd3,
      ALU_AND  = 7'd4,
      ALU_SRA  = 7'd5,
      ALU_SRL  = 7'd6,
      ALU_SLL  = 7'd7,
      ALU_LT   = 7'd8,
      ALU_LTU  = 7'd9,
      ALU_GE   = 7'd10,
      ALU_GEU  = 7'd11,
      ALU_EQ   = 7'd12,
      ALU_NE   = 7'd13,
      ALU_MIN  = 7'd14,
      ALU_MINU = 7'd15,
      ALU_MAX  = 7'd16,
      ALU_MAXU = 7'd17,
      ALU_SLT  = 7'd18,
      ALU_SLTU = 7'd19
   } alu_op_e;

   // Operands are sign-extended into the extra adder bit for these opcodes.
   function automatic logic bma_is_signed(alu_op_e op);
      return op inside {ALU_LT, ALU_GE, ALU_SLT, ALU_MIN, ALU_MAX};
   endfunction

   // Opcodes this adder/comparator can execute; everything else reports err.
   function automatic logic bma_op_supported(alu_op_e op);
      logic sup;
      sup = op inside {ALU_ADD, ALU_SUB, ALU_LT, ALU_LTU, ALU_GE, ALU_GEU,
                       ALU_EQ, ALU_NE, ALU_SLT, ALU_SLTU};
`ifdef IBEX_BMA_MINMAX_EN
      sup = sup | (op inside {ALU_MIN, ALU_MINU, ALU_MAX, ALU_MAXU});
`endif
      return sup;
   endfunction

endpackage

// File: rtl/ibex_bma_pipe_reg.sv
// ibex_bma_pipe_reg: one valid/ready pipeline slot. Loads when the slot is
// empty or being drained in the same cycle; flush and reset empty it.
module ibex_bma_pipe_reg #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o
);

   logic              valid_d, valid_q;
   logic [DATA_W-1:0] data_d, data_q;
   logic              load;

   // Next-state: flush beats any load; a consumed entry empties the slot.
   always_comb begin
      in_ready_o = !flush_i && (!valid_q || out_ready_i);
      load       = in_valid_i && in_ready_o;
      valid_d    = valid_q;
      data_d     = data_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         data_d  = in_data_i;
      end else if (out_ready_i) begin
         valid_d = 1'b0;
      end
   end

   // Slot registers; payload also cleared on reset so outputs read as zero.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;

endmodule

// File: rtl/ibex_branch_mul_alu_pipe.sv
// ibex_branch_mul_alu_pipe: pipelined (WIDTH+1)-bit adder/comparator shared by
// the branch and MUL paths. SPLIT_ADDER=1 computes the low half in stage 1 and
// the high half plus compare in stage 2; results are bit-identical to 1 stage.
// Optional feature macro: IBEX_BMA_MINMAX_EN (ALU_MIN/MINU/MAX/MAXU).
module ibex_branch_mul_alu_pipe
   import ibex_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned SPLIT_ADDER = 0,
   parameter int unsigned TAG_W       = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  alu_op_e          operator_i,
   input  logic [WIDTH-1:0] operand_a_i,
   input  logic [WIDTH-1:0] operand_b_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] result_o,
   output logic             cmp_result_o,
   output logic             err_o,
   output logic [TAG_W-1:0] tag_o
);

   localparam int unsigned OP_W  = $bits(alu_op_e);
   localparam int unsigned OUT_W = TAG_W + 2 + WIDTH;

   // Inputs to the final (output) stage: opcode, tag and completed difference.
   logic             fin_valid, fin_ready;
   alu_op_e          fin_op;
   logic [WIDTH:0]   fin_diff;
   logic [TAG_W-1:0] fin_tag;
`ifdef IBEX_BMA_MINMAX_EN
   logic [WIDTH-1:0] fin_a, fin_b;
`endif
   logic [WIDTH-1:0] fin_result;
   logic             fin_cmp, fin_err, fin_eq, fin_lt;
   logic [OUT_W-1:0] out_data;

   if (SPLIT_ADDER == 0) begin : g_single
      logic [WIDTH:0] a_ext, b_ext;

      // Whole (WIDTH+1)-bit add/subtract in one stage.
      always_comb begin
         a_ext    = {bma_is_signed(operator_i) & operand_a_i[WIDTH-1], operand_a_i};
         b_ext    = {bma_is_signed(operator_i) & operand_b_i[WIDTH-1], operand_b_i};
         fin_diff = (operator_i == ALU_ADD) ? (a_ext + b_ext) : (a_ext - b_ext);
      end

      assign fin_valid  = in_valid_i;
      assign in_ready_o = fin_ready;
      assign fin_op     = operator_i;
      assign fin_tag    = tag_i;
`ifdef IBEX_BMA_MINMAX_EN
      assign fin_a      = operand_a_i;
      assign fin_b      = operand_b_i;
`endif
   end else begin : g_split
      localparam int unsigned LO_W = WIDTH / 2;
      localparam int unsigned HB_W = WIDTH - LO_W;
      localparam int unsigned HI_W = HB_W + 1;
`ifdef IBEX_BMA_MINMAX_EN
      // Full operands travel to stage 2 for the min/max select.
      localparam int unsigned OPND_W = WIDTH;
`else
      // Only the high operand halves are still needed in stage 2.
      localparam int unsigned OPND_W = HB_W;
`endif
      localparam int unsigned S1_W = TAG_W + OP_W + 2 * OPND_W + LO_W + 1;

      logic              in_sub;
      logic [LO_W-1:0]   b_lo;
      logic [LO_W:0]     lo_sum;
      logic [S1_W-1:0]   s1_in, s1_out;
      logic              s1_valid;
      logic [TAG_W-1:0]  s1_tag;
      logic [OP_W-1:0]   s1_op;
      logic [OPND_W-1:0] s1_a, s1_b;
      logic              s1_carry;
      logic [LO_W-1:0]   s1_lo;
      logic              s2_sub, s2_sgn;
      logic [HI_W-1:0]   a_hi, b_hi, hi_sum;

      // Stage 1: low half; subtraction is a + ~b with carry-in 1.
      always_comb begin
         in_sub = (operator_i != ALU_ADD);
         b_lo   = in_sub ? ~operand_b_i[LO_W-1:0] : operand_b_i[LO_W-1:0];
         lo_sum = {1'b0, operand_a_i[LO_W-1:0]} + {1'b0, b_lo} + {{LO_W{1'b0}}, in_sub};
      end

      assign s1_in = {tag_i, operator_i, operand_a_i[WIDTH-1 -: OPND_W],
                      operand_b_i[WIDTH-1 -: OPND_W], lo_sum};

      ibex_bma_pipe_reg #(.DATA_W(S1_W)) u_stage1 (
         .clk_i       (clk_i),
         .rst_i       (rst_i),
         .flush_i     (flush_i),
         .in_valid_i  (in_valid_i),
         .in_ready_o  (in_ready_o),
         .in_data_i   (s1_in),
         .out_valid_o (s1_valid),
         .out_ready_i (fin_ready),
         .out_data_o  (s1_out)
      );

      assign {s1_tag, s1_op, s1_a, s1_b, s1_carry, s1_lo} = s1_out;

      // Stage 2: high half (incl. extension bit) using stage-1 carry.
      always_comb begin
         fin_op = alu_op_e'(s1_op);
         s2_sub = (fin_op != ALU_ADD);
         s2_sgn = bma_is_signed(fin_op);
         a_hi   = {s2_sgn & s1_a[OPND_W-1], s1_a[OPND_W-1 -: HB_W]};
         b_hi   = {s2_sgn & s1_b[OPND_W-1], s1_b[OPND_W-1 -: HB_W]};
         if (s2_sub) begin
            b_hi = ~b_hi;
         end
         hi_sum   = a_hi + b_hi + {{(HI_W-1){1'b0}}, s1_carry};
         fin_diff = {hi_sum, s1_lo};
      end

      assign fin_valid = s1_valid;
      assign fin_tag   = s1_tag;
`ifdef IBEX_BMA_MINMAX_EN
      assign fin_a     = s1_a;
      assign fin_b     = s1_b;
`endif
   end

   // Result/compare selection from the finished difference.
   always_comb begin
      fin_eq     = (fin_diff[WIDTH-1:0] == '0);
      fin_lt     = fin_diff[WIDTH];
      fin_result = fin_diff[WIDTH-1:0];
      fin_cmp    = 1'b0;
      fin_err    = 1'b0;
      if (!bma_op_supported(fin_op)) begin
         fin_err    = 1'b1;
         fin_result = '0;
      end else begin
         case (fin_op)
            ALU_EQ:                              fin_cmp = fin_eq;
            ALU_NE:                              fin_cmp = !fin_eq;
            ALU_LT, ALU_LTU, ALU_SLT, ALU_SLTU:  fin_cmp = fin_lt;
            ALU_GE, ALU_GEU:                     fin_cmp = !fin_lt;
`ifdef IBEX_BMA_MINMAX_EN
            ALU_MIN, ALU_MINU: begin
               fin_result = fin_lt ? fin_a : fin_b;
               fin_cmp    = fin_lt;
            end
            ALU_MAX, ALU_MAXU: begin
               fin_result = fin_lt ? fin_b : fin_a;
               fin_cmp    = !fin_lt;
            end
`endif
            default:                             fin_cmp = 1'b0;
         endcase
      end
   end

   ibex_bma_pipe_reg #(.DATA_W(OUT_W)) u_out (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .in_valid_i  (fin_valid),
      .in_ready_o  (fin_ready),
      .in_data_i   ({fin_tag, fin_err, fin_cmp, fin_result}),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data)
   );

   assign {tag_o, err_o, cmp_result_o, result_o} = out_data;

endmodule

// File: tb/tb_ibex_branch_mul_alu_pipe.sv
// Testbench for ibex_branch_mul_alu_pipe: four configurations (WIDTH 8/32 x
// SPLIT_ADDER 0/1) run side by side, each with a driver, a ready driver and a
// scoreboard monitor checking against an arithmetic reference model.
// Optional feature macro: IBEX_BMA_MINMAX_EN (model follows the same define).
module tb_ibex_branch_mul_alu_pipe;
   import ibex_pkg::*;

   localparam int unsigned TW = 4;
`ifdef IBEX_BMA_MINMAX_EN
   localparam bit MINMAX = 1'b1;
`else
   localparam bit MINMAX = 1'b0;
`endif

   typedef struct {
      logic [31:0]   r;
      logic          c;
      logic          e;
      logic [TW-1:0] t;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   bit   go_after_rst = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   task automatic check(input bit ok, input string what);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s", what);
      end
   endtask

   for (genvar gi = 0; gi < 4; gi++) begin : g_cfg
      localparam int unsigned W  = (gi >= 2) ? 32 : 8;
      localparam int unsigned SP = gi % 2;

      logic          in_valid = 1'b0;
      logic          in_ready;
      logic          flush = 1'b0;
      logic          out_valid;
      logic          out_ready = 1'b1;
      logic          cmp, err;
      alu_op_e       op = ALU_ADD;
      logic [W-1:0]  a = '0, b = '0, res;
      logic [TW-1:0] tag = '0, tag_o;
      logic [TW-1:0] tag_cnt = '0;
      exp_t          q[$];
      int            rdy_mode = 0;   // 0: always ready, 1: random, 2: never
      int            stall_cnt = 0;
      bit            p1_done = 1'b0;
      bit            done = 1'b0;

      ibex_branch_mul_alu_pipe #(.WIDTH(W), .SPLIT_ADDER(SP), .TAG_W(TW)) u_dut (
         .clk_i        (clk),
         .rst_i        (rst),
         .flush_i      (flush),
         .in_valid_i   (in_valid),
         .in_ready_o   (in_ready),
         .operator_i   (op),
         .operand_a_i  (a),
         .operand_b_i  (b),
         .tag_i        (tag),
         .out_valid_o  (out_valid),
         .out_ready_i  (out_ready),
         .result_o     (res),
         .cmp_result_o (cmp),
         .err_o        (err),
         .tag_o        (tag_o)
      );

      // Reference: compare operands as integers, results mod 2^W.
      function automatic exp_t model(input alu_op_e o, input logic [W-1:0] x,
                                     input logic [W-1:0] y, input logic [TW-1:0] t);
         exp_t         e;
         longint       sx, sy;
         bit           sg, lt, eq;
         logic [W-1:0] r;
         sg = o inside {ALU_LT, ALU_GE, ALU_SLT, ALU_MIN, ALU_MAX};
         sx = sg ? longint'($signed(x)) : longint'(x);
         sy = sg ? longint'($signed(y)) : longint'(y);
         lt = (sx < sy);
         eq = (x == y);
         r  = x - y;
         e.c = 1'b0;
         e.e = 1'b0;
         e.t = t;
         case (o)
            ALU_ADD:                             r = x + y;
            ALU_SUB:                             e.c = 1'b0;
            ALU_EQ:                              e.c = eq;
            ALU_NE:                              e.c = !eq;
            ALU_LT, ALU_LTU, ALU_SLT, ALU_SLTU:  e.c = lt;
            ALU_GE, ALU_GEU:                     e.c = !lt;
            ALU_MIN, ALU_MINU: begin
               if (MINMAX) begin r = lt ? x : y; e.c = lt; end
               else begin r = '0; e.e = 1'b1; end
            end
            ALU_MAX, ALU_MAXU: begin
               if (MINMAX) begin r = lt ? y : x; e.c = !lt; end
               else begin r = '0; e.e = 1'b1; end
            end
            default: begin r = '0; e.e = 1'b1; end
         endcase
         e.r = 32'(r);
         return e;
      endfunction

      task automatic issue(input alu_op_e o, input logic [W-1:0] x, input logic [W-1:0] y);
         bit acc;
         acc = 1'b0;
         @(posedge clk); #1;
         in_valid = 1'b1; op = o; a = x; b = y; tag = tag_cnt;
         for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
         end
         check(acc, $sformatf("accept cfg%0d in_ready=%0b required 1 within 200 cycles", gi, in_ready));
         if (acc) begin
            q.push_back(model(o, x, y, tag_cnt));
            tag_cnt++;
         end
      endtask

      task automatic idle();
         @(posedge clk); #1;
         in_valid = 1'b0;
      endtask

      task automatic drain();
         for (int c = 0; c < 300 && q.size() != 0; c++) @(negedge clk);
         check(q.size() == 0, $sformatf("drain cfg%0d pending=%0d required 0", gi, q.size()));
      endtask

      task automatic do_flush();
         @(posedge clk); #1;
         flush = 1'b1; in_valid = 1'b1; op = ALU_SUB; tag = tag_cnt;
         @(negedge clk);
         check(!in_ready, $sformatf("flush_ready cfg%0d in_ready=%0b required 0", gi, in_ready));
         @(posedge clk); #1;
         flush = 1'b0; in_valid = 1'b0;
         @(negedge clk);
         check(!out_valid, $sformatf("post_flush cfg%0d out_valid=%0b required 0", gi, out_valid));
      endtask

      task automatic rand_op(output alu_op_e o, output logic [W-1:0] x, output logic [W-1:0] y);
         logic [W-1:0] msb;
         msb = '0; msb[W-1] = 1'b1;
         o = alu_op_e'($urandom_range(0, 19));
         x = W'($urandom);
         y = W'($urandom);
         case ($urandom_range(0, 5))
            0: y = x;
            1: x = msb;
            2: y = msb | W'($urandom_range(0, 3));
            3: x = '1;
            default: ;
         endcase
      endtask

      // Output-ready driver: random, forced, or stalled for stall_cnt cycles.
      initial begin : rdy_drv
         forever begin
            @(posedge clk); #1;
            if (stall_cnt > 0) begin
               out_ready = 1'b0;
               stall_cnt--;
            end else if (rdy_mode == 1) begin
               out_ready = 1'($urandom_range(0, 1));
            end else begin
               out_ready = (rdy_mode == 0);
            end
         end
      end

      // Monitor: pops expected responses on handshake, checks held outputs.
      initial begin : mon
         logic [W-1:0]  p_res;
         logic          p_cmp, p_err;
         logic [TW-1:0] p_tag;
         bit            hold;
         exp_t          e;
         hold = 1'b0;
         forever begin
            @(negedge clk);
            if (rst) begin
               q.delete();
               hold = 1'b0;
            end else begin
               if (hold) begin
                  check(out_valid && res == p_res && cmp == p_cmp && err == p_err && tag_o == p_tag,
                        $sformatf("hold cfg%0d valid=%0b res=%h cmp=%0b err=%0b tag=%h required valid=1 res=%h cmp=%0b err=%0b tag=%h",
                                  gi, out_valid, res, cmp, err, tag_o, p_res, p_cmp, p_err, p_tag));
               end
               if (out_valid && out_ready) begin
                  check(q.size() != 0, $sformatf("unexpected cfg%0d tag=%h res=%h with no pending request", gi, tag_o, res));
                  if (q.size() != 0) begin
                     e = q.pop_front();
                     check(res == e.r[W-1:0] && cmp == e.c && err == e.e && tag_o == e.t,
                           $sformatf("resp cfg%0d got res=%h cmp=%0b err=%0b tag=%h required res=%h cmp=%0b err=%0b tag=%h",
                                     gi, res, cmp, err, tag_o, e.r[W-1:0], e.c, e.e, e.t));
                     $display("txn cfg%0d tag=%h res=%h cmp=%0b err=%0b", gi, tag_o, res, cmp, err);
                  end
               end
               hold  = out_valid && !out_ready && !flush;
               p_res = res; p_cmp = cmp; p_err = err; p_tag = tag_o;
               if (flush) q.delete();
            end
         end
      end

      // Driver: directed cases, then random traffic with stalls and flushes.
      initial begin : drv
         logic [W-1:0] ones, msb, one, m5, three, ra, rb;
         alu_op_e      ro;
         int           lat;
         ones = '1; msb = '0; msb[W-1] = 1'b1; one = W'(1); m5 = W'(-5); three = W'(3);

         repeat (2) @(negedge clk);
         check(!out_valid && res == '0 && !cmp && !err && tag_o == '0,
               $sformatf("reset cfg%0d valid=%0b res=%h cmp=%0b err=%0b tag=%h required all 0",
                         gi, out_valid, res, cmp, err, tag_o));
         while (rst) @(negedge clk);

         // Latency with an empty pipe and out_ready held high.
         idle();
         issue(ALU_ADD, ones, one);
         @(posedge clk); #1;
         in_valid = 1'b0;
         lat = 0;
         do begin
            @(negedge clk);
            lat++;
         end while (!out_valid && lat < 8);
         check(lat == int'(SP) + 1, $sformatf("latency cfg%0d got %0d required %0d", gi, lat, int'(SP) + 1));

         // Signed vs unsigned compares around the MSB, and MAX.
         issue(ALU_LT, msb, one);
         issue(ALU_LTU, msb, one);
         issue(ALU_GEU, msb, one);
         issue(ALU_MAX, m5, three);
         idle();
         drain();

         // Eight back-to-back ops with a 3-cycle output stall mid-stream.
         for (int i = 0; i < 8; i++) begin
            if (i == 3) stall_cnt = 3;
            rand_op(ro, ra, rb);
            issue(ro, ra, rb);
         end
         idle();
         drain();

         // Flush with work in flight and a request pending.
         rdy_mode = 2;
         idle();
         issue(ALU_SUB, three, one);
         if (SP != 0) issue(ALU_EQ, three, three);
         do_flush();
         rdy_mode = 0;

         // Random traffic with random backpressure and occasional flushes.
         rdy_mode = 1;
         for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               idle();
            end else if ($urandom_range(0, 24) == 0) begin
               do_flush();
            end else begin
               rand_op(ro, ra, rb);
               issue(ro, ra, rb);
            end
         end
         idle();
         rdy_mode = 0;
         drain();

         // Leave one op stalled in the pipe for the mid-operation reset.
         rdy_mode = 2;
         idle();
         issue(ALU_SUB, ones, one);
         idle();
         p1_done = 1'b1;
         wait (go_after_rst);
         @(negedge clk);
         check(!out_valid && res == '0 && tag_o == '0,
               $sformatf("mid_reset cfg%0d valid=%0b res=%h tag=%h required 0 0 0", gi, out_valid, res, tag_o));

         rdy_mode = 0;
         for (int i = 0; i < 6; i++) begin
            rand_op(ro, ra, rb);
            issue(ro, ra, rb);
         end
         idle();
         drain();
         done = 1'b1;
      end
   end

   initial begin : main
      bit all;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;

      all = 1'b0;
      for (int c = 0; c < 20000 && !all; c++) begin
         @(posedge clk);
         all = g_cfg[0].p1_done && g_cfg[1].p1_done && g_cfg[2].p1_done && g_cfg[3].p1_done;
      end
      check(all, $sformatf("phase1_timeout done=%0b required 1", all));

      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      go_after_rst = 1'b1;

      all = 1'b0;
      for (int c = 0; c < 20000 && !all; c++) begin
         @(posedge clk);
         all = g_cfg[0].done && g_cfg[1].done && g_cfg[2].done && g_cfg[3].done;
      end
      check(all, $sformatf("final_timeout done=%0b required 1", all));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
